conv_seq_ctrl: RTL and testbench

- Sequencer for the 1-D convolution datapath: Z[n] = sum over k of X[k]*Y[n-k], for n = 0 .. SX+SY-2.
- Sits between the AIP config/start logic and the X/Y input memories, the MAC unit and the Z output memory.
- Latches the sizes on start and issues one X/Y read pair per cycle.
- Tags each read so the MAC clears/accumulates on the right data, writes each finished Z sample, then pulses done for the interrupt/status logic.

---
 rtl/conv_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: read/accumulate/write sequencer for the 1-D convolution
// Z[n] = sum_k X[k]*Y[n-k].
// It latches the sizes on start and issues one X/Y read per cycle. Each read
// carries first/last tags down a MEM_LAT-deep pipeline. That pipeline drives
// the MAC clear/enable and the Z write strobe. done pulses at the end of the run.
// MEM_LAT must lie in 1..3.
// Optional build macro: CONV_SEQ_CYCLE_CNT_EN adds a 16-bit start-to-done
// cycle counter on output cycle_cnt.
module conv_seq_ctrl #(
    parameter int SIZE_W  = 5,
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              start,
    input  logic [SIZE_W-1:0] size_x,
    input  logic [SIZE_W-1:0] size_y,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_x_addr,
    output logic [ADDR_W-1:0] mem_y_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mem_z_we,
    output logic [ADDR_W:0]   mem_z_addr
`ifdef CONV_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [SIZE_W-1:0] S_ZERO = {SIZE_W{1'b0}};
    localparam logic [SIZE_W-1:0] S_ONE  = {{(SIZE_W-1){1'b0}}, 1'b1};
    localparam logic [SIZE_W:0]   N_ZERO = {(SIZE_W+1){1'b0}};
    localparam logic [SIZE_W:0]   N_ONE  = {{SIZE_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   Z_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [1:0]        DRAIN_LOAD = 2'(MEM_LAT);

    state_t              state_r, state_next;
    logic [SIZE_W-1:0]   sx_r, sx_next;
    logic [SIZE_W-1:0]   sy_r, sy_next;
    logic [SIZE_W:0]     n_r, n_next;        // output index n
    logic [SIZE_W-1:0]   k_r, k_next;        // X index k
    logic [SIZE_W-1:0]   j_r, j_next;        // Y index n-k, tracked directly
    logic [1:0]          drain_r, drain_next;

    logic                first_s, last_s, end_s;
    logic [SIZE_W:0]     n_inc_s, sy_m1_s, y_start_s;

    logic                busy_r, done_r, err_r, mem_rd_r;
    logic [ADDR_W-1:0]   x_addr_r, y_addr_r;
    logic                z_we_r;
    logic [ADDR_W:0]     z_addr_r;

    // Tag pipeline: valid, clear (valid & first), write (valid & last), Z address
    logic                pipe_v_r [MEM_LAT];
    logic                pipe_c_r [MEM_LAT];
    logic                pipe_l_r [MEM_LAT];
    logic [ADDR_W:0]     pipe_z_r [MEM_LAT];

    // Tag decode for the read issued this cycle. k_lo is reached when k hits
    // 0 or n-k hits SY-1. k_hi is reached when k hits SX-1 or n-k hits 0.
    always_comb begin
        first_s   = (k_r == S_ZERO) || (j_r == (sy_r - S_ONE));
        last_s    = (k_r == (sx_r - S_ONE)) || (j_r == S_ZERO);
        end_s     = (k_r == (sx_r - S_ONE)) && (j_r == (sy_r - S_ONE));
        n_inc_s   = n_r + N_ONE;
        sy_m1_s   = {1'b0, sy_r} - N_ONE;
        y_start_s = (n_inc_s < sy_m1_s) ? n_inc_s : sy_m1_s;
    end

    // Next-state and index sequencing
    always_comb begin
        state_next = state_r;
        sx_next    = sx_r;
        sy_next    = sy_r;
        n_next     = n_r;
        k_next     = k_r;
        j_next     = j_r;
        drain_next = drain_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sx_next = size_x;
                    sy_next = size_y;
                    n_next  = N_ZERO;
                    k_next  = S_ZERO;
                    j_next  = S_ZERO;
                    if ((size_x == S_ZERO) || (size_y == S_ZERO)) begin
                        state_next = FIN;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    if (end_s) begin
                        state_next = DRAIN;
                        drain_next = DRAIN_LOAD;
                    end else begin
                        // New n: Y index restarts at min(n+1, SY-1), k = n+1 - that
                        n_next = n_inc_s;
                        j_next = SIZE_W'(y_start_s);
                        k_next = SIZE_W'(n_inc_s - y_start_s);
                    end
                end else begin
                    k_next = k_r + S_ONE;
                    j_next = j_r - S_ONE;
                end
            end
            DRAIN: begin
                if (drain_r == 2'b00) begin
                    state_next = FIN;
                end else begin
                    drain_next = drain_r - 2'b01;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and index registers
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_r <= IDLE;
            sx_r    <= S_ZERO;
            sy_r    <= S_ZERO;
            n_r     <= N_ZERO;
            k_r     <= S_ZERO;
            j_r     <= S_ZERO;
            drain_r <= 2'b00;
        end else begin
            state_r <= state_next;
            sx_r    <= sx_next;
            sy_r    <= sy_next;
            n_r     <= n_next;
            k_r     <= k_next;
            j_r     <= j_next;
            drain_r <= drain_next;
        end
    end

    // Registered control outputs, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst_a) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            mem_rd_r <= 1'b0;
            x_addr_r <= A_ZERO;
            y_addr_r <= A_ZERO;
        end else begin
            busy_r   <= (state_next == RUN) || (state_next == DRAIN);
            done_r   <= (state_next == FIN);
            // Only a zero-size start jumps straight from IDLE to FIN
            err_r    <= (state_next == FIN) && (state_r == IDLE);
            mem_rd_r <= (state_next == RUN);
            x_addr_r <= (state_next == RUN) ? ADDR_W'(k_next) : A_ZERO;
            y_addr_r <= (state_next == RUN) ? ADDR_W'(j_next) : A_ZERO;
        end
    end

    // Tag pipeline, MEM_LAT deep, so the tags line up with the read data
    always_ff @(posedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_v_r[i] <= 1'b0;
                pipe_c_r[i] <= 1'b0;
                pipe_l_r[i] <= 1'b0;
                pipe_z_r[i] <= Z_ZERO;
            end
        end else begin
            pipe_v_r[0] <= mem_rd_r;
            pipe_c_r[0] <= mem_rd_r & first_s;
            pipe_l_r[0] <= mem_rd_r & last_s;
            pipe_z_r[0] <= (ADDR_W+1)'(n_r);
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_c_r[i] <= pipe_c_r[i-1];
                pipe_l_r[i] <= pipe_l_r[i-1];
                pipe_z_r[i] <= pipe_z_r[i-1];
            end
        end
    end

    // Z write one cycle after the last product of each n reaches the accumulator
    always_ff @(posedge clk) begin
        if (rst_a) begin
            z_we_r   <= 1'b0;
            z_addr_r <= Z_ZERO;
        end else begin
            z_we_r   <= pipe_l_r[MEM_LAT-1];
            z_addr_r <= pipe_l_r[MEM_LAT-1] ? pipe_z_r[MEM_LAT-1] : Z_ZERO;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign mem_rd     = mem_rd_r;
    assign mem_x_addr = x_addr_r;
    assign mem_y_addr = y_addr_r;
    assign mac_en     = pipe_v_r[MEM_LAT-1];
    assign mac_clr    = pipe_c_r[MEM_LAT-1];
    assign mem_z_we   = z_we_r;
    assign mem_z_addr = z_addr_r;

`ifdef CONV_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc_cnt_r;

    // Start-to-done latency: counts busy cycles plus the done cycle, then holds
    always_ff @(posedge clk) begin
        if (rst_a) begin
            cyc_cnt_r <= 16'd0;
        end else if ((state_r == IDLE) && start) begin
            cyc_cnt_r <= 16'd0;
        end else if (busy_r || done_r) begin
            cyc_cnt_r <= cyc_cnt_r + 16'd1;
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    assign cycle_cnt = cyc_cnt_r;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl. It runs two instances side by side, one with
// MEM_LAT=1 and one with MEM_LAT=3. A behavioural memory/MAC model checks
// every Z write against a software convolution.
module tb_conv_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       start;
    logic [4:0] size_x, size_y;

    logic       busy_o [2];
    logic       done_o [2];
    logic       err_o  [2];
    logic       rd_o   [2];
    logic       clr_o  [2];
    logic       en_o   [2];
    logic       we_o   [2];
    logic [4:0] x_o    [2];
    logic [4:0] y_o    [2];
    logic [5:0] z_o    [2];

    conv_seq_ctrl #(.SIZE_W(5), .ADDR_W(5), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_a(rst_a), .start(start), .size_x(size_x), .size_y(size_y),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .mem_rd(rd_o[0]),
        .mem_x_addr(x_o[0]), .mem_y_addr(y_o[0]), .mac_clr(clr_o[0]), .mac_en(en_o[0]),
        .mem_z_we(we_o[0]), .mem_z_addr(z_o[0]));

    conv_seq_ctrl #(.SIZE_W(5), .ADDR_W(5), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_a(rst_a), .start(start), .size_x(size_x), .size_y(size_y),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .mem_rd(rd_o[1]),
        .mem_x_addr(x_o[1]), .mem_y_addr(y_o[1]), .mac_clr(clr_o[1]), .mac_en(en_o[1]),
        .mem_z_we(we_o[1]), .mem_z_addr(z_o[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     xv [32];
    int     yv [32];
    longint conv_ref [64];

    int total = 0;
    int bad   = 0;

    // ---------------- monitor / memory + MAC model ----------------
    int     rd_cnt [2], wr_cnt [2], dn_cnt [2], er_cnt [2], clr_cnt [2], bz_cnt [2], zbad [2];
    int     last_done [2], last_z [2], z_next [2];
    longint acc_m [2];
    int     hist_p [2][8];
    bit     hist_v [2][8];
    bit     busy_prev [2];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (busy_o[u] && !busy_prev[u]) z_next[u] <= 0;
            else if (we_o[u]) z_next[u] <= int'(z_o[u]) + 1;
            busy_prev[u] <= busy_o[u];
            if (we_o[u]) begin
                wr_cnt[u] <= wr_cnt[u] + 1;
                last_z[u] <= int'(z_o[u]);
            end
            // write data is the accumulator before this cycle's update
            zbad[u] <= zbad[u]
                + ((we_o[u] && ((int'(z_o[u]) != z_next[u]) || (acc_m[u] != conv_ref[z_o[u]]))) ? 1 : 0)
                + ((en_o[u] && !hist_v[u][3'(cyc - ((u == 0) ? 1 : 3))]) ? 1 : 0)
                + ((clr_o[u] && !en_o[u]) ? 1 : 0)
                + ((err_o[u] && !done_o[u]) ? 1 : 0);
            if (en_o[u])
                acc_m[u] <= (clr_o[u] ? 64'sd0 : acc_m[u])
                            + longint'(hist_p[u][3'(cyc - ((u == 0) ? 1 : 3))]);
            hist_v[u][3'(cyc)] <= rd_o[u];
            hist_p[u][3'(cyc)] <= xv[x_o[u]] * yv[y_o[u]];
            rd_cnt[u]  <= rd_cnt[u]  + (rd_o[u] ? 1 : 0);
            clr_cnt[u] <= clr_cnt[u] + ((clr_o[u] && en_o[u]) ? 1 : 0);
            bz_cnt[u]  <= bz_cnt[u]  + (busy_o[u] ? 1 : 0);
            er_cnt[u]  <= er_cnt[u]  + (err_o[u] ? 1 : 0);
            if (done_o[u]) begin
                dn_cnt[u]    <= dn_cnt[u] + 1;
                last_done[u] <= cyc;
            end
        end
    end

    typedef struct {
        int rd, wr, dn, er, clr, bz, zb;
    } cnt_t;

    function automatic cnt_t snap(input int u);
        cnt_t c;
        c.rd = rd_cnt[u]; c.wr = wr_cnt[u]; c.dn = dn_cnt[u]; c.er = er_cnt[u];
        c.clr = clr_cnt[u]; c.bz = bz_cnt[u]; c.zb = zbad[u];
        return c;
    endfunction

    function automatic longint outs(input int u);
        return longint'({busy_o[u], done_o[u], err_o[u], rd_o[u], x_o[u], y_o[u],
                         clr_o[u], en_o[u], we_o[u], z_o[u]});
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compute_ref(input int sx, input int sy);
        for (int n = 0; n < 64; n++) conv_ref[n] = 0;
        for (int k = 0; k < sx; k++)
            for (int j = 0; j < sy; j++)
                conv_ref[k + j] += longint'(xv[k] * yv[j]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int sx, sy, reads, writes, done1, done3, busy1, busy3, err;
    } vec_t;
    vec_t tbl [7];

    typedef struct packed {
        logic       rd;
        logic [4:0] x;
        logic [4:0] y;
        logic       en;
        logic       clr;
        logic       we;
        logic [5:0] z;
        logic       busy;
        logic       done;
    } cv_t;
    cv_t seq [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input int idx, input int repulse);
        vec_t v;
        cnt_t b [2];
        cnt_t a [2];
        int   t0;
        int   n;
        v = tbl[idx];
        compute_ref(v.sx, v.sy);
        b[0] = snap(0);
        b[1] = snap(1);
        tick();
        start = 1'b1; size_x = 5'(v.sx); size_y = 5'(v.sy); t0 = cyc;
        tick();
        start = 1'b0; size_x = 5'd17; size_y = 5'd9;
        if (repulse > 0) begin
            repeat (repulse - 1) tick();
            start = 1'b1; size_x = 5'd3; size_y = 5'd2;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (((snap(0).dn == b[0].dn) || (snap(1).dn == b[1].dn)) && (n < 1500)) begin
            tick();
            n++;
        end
        check($sformatf("run%0d_rp%0d_finished", idx, repulse), longint'(n >= 1500), 0);
        repeat (4) tick();
        a[0] = snap(0);
        a[1] = snap(1);
        for (int u = 0; u < 2; u++) begin
            string p;
            p = $sformatf("sx%0d_sy%0d_rp%0d_lat%0d", v.sx, v.sy, repulse, (u == 0) ? 1 : 3);
            check({p, "_reads"},  a[u].rd - b[u].rd, v.reads);
            check({p, "_writes"}, a[u].wr - b[u].wr, v.writes);
            check({p, "_clrs"},   a[u].clr - b[u].clr, v.writes);
            check({p, "_dones"},  a[u].dn - b[u].dn, 1);
            check({p, "_errs"},   a[u].er - b[u].er, v.err);
            check({p, "_done_at"}, last_done[u] - t0, (u == 0) ? v.done1 : v.done3);
            check({p, "_busy_cycles"}, a[u].bz - b[u].bz, (u == 0) ? v.busy1 : v.busy3);
            check({p, "_z_order_data"}, a[u].zb - b[u].zb, 0);
            if (v.writes > 0) check({p, "_last_zaddr"}, last_z[u], v.writes - 1);
        end
    endtask

    initial begin
        cnt_t b0, b1;
        int   t0;
        for (int i = 0; i < 32; i++) begin
            xv[i] = i + 1;
            yv[i] = i + 1;
        end
        //          sx  sy reads wr done1 done3 busy1 busy3 err
        tbl[0] = '{  3,  2,   6,  4,   9,   11,    8,   10,  0};
        tbl[1] = '{ 10,  5,  50, 14,  53,   55,   52,   54,  0};
        tbl[2] = '{  0,  5,   0,  0,   1,    1,    0,    0,  1};
        tbl[3] = '{  5,  0,   0,  0,   1,    1,    0,    0,  1};
        tbl[4] = '{  1,  1,   1,  1,   4,    6,    3,    5,  0};
        tbl[5] = '{  4,  7,  28, 10,  31,   33,   30,   32,  0};
        tbl[6] = '{ 31, 31, 961, 61, 964,  966,  963,  965,  0};
        //           rd   x     y     en    clr   we    z     busy  done
        seq[0] = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0};
        seq[1] = '{1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0};
        seq[2] = '{1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0};
        seq[3] = '{1'b1, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0};
        seq[4] = '{1'b1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0};
        seq[5] = '{1'b1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0};
        seq[6] = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0};
        seq[7] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0};
        seq[8] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1};

        rst_a = 1'b1; start = 1'b0; size_x = 5'd0; size_y = 5'd0;
        repeat (3) tick();
        check("reset_outputs_lat1", outs(0), 0);
        check("reset_outputs_lat3", outs(1), 0);
        rst_a = 1'b0;
        repeat (2) tick();

        // Cycle-exact 3x2 run on the MEM_LAT=1 instance
        compute_ref(3, 2);
        start = 1'b1; size_x = 5'd3; size_y = 5'd2; t0 = cyc;
        tick();
        start = 1'b0; size_x = 5'd7; size_y = 5'd7;
        for (int i = 0; i < 9; i++) begin
            cv_t a;
            a = {rd_o[0], x_o[0], y_o[0], en_o[0], clr_o[0], we_o[0], z_o[0], busy_o[0], done_o[0]};
            check($sformatf("seq3x2_cycle_t0+%0d", cyc - t0), longint'(a), longint'(seq[i]));
            tick();
        end
        repeat (6) tick();

        for (int i = 0; i < 7; i++) do_run(i, 0);

        // Start re-pulsed mid-run with other sizes must be ignored
        do_run(1, 10);

        // Reset in the middle of a 10x5 run
        compute_ref(10, 5);
        tick();
        start = 1'b1; size_x = 5'd10; size_y = 5'd5; t0 = cyc;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("midrun_reset_outputs_lat1", outs(0), 0);
        check("midrun_reset_outputs_lat3", outs(1), 0);
        b0 = snap(0);
        b1 = snap(1);
        repeat (60) tick();
        check("after_reset_writes_lat1", snap(0).wr - b0.wr, 0);
        check("after_reset_writes_lat3", snap(1).wr - b1.wr, 0);
        check("after_reset_dones_lat1", snap(0).dn - b0.dn, 0);
        check("after_reset_dones_lat3", snap(1).dn - b1.dn, 0);
        do_run(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
